biquad_snap_capture: RTL and testbench

- Debug snapshot buffer on the 8-sample-per-clock filtered stream: the unpacked 96-bit biquad8 output (12-bit samples).
- Free-runs a circular write into block RAM with a programmable pretrigger depth.
- Stops after a full buffer once a threshold or forced trigger fires, then exposes a synchronous read port for register readout.
- Sits in the aclk domain beside the pack/DAC transfer path and never back-pressures it.

---
 rtl/biquad_snap_capture.sv | 159 +++++++++++++++
 tb/tb_biquad_snap_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_snap_capture.sv
// Debug snapshot buffer for the 8-sample filtered stream: circular capture with
// programmable pretrigger, threshold/forced trigger, and a registered readout port.
module biquad_snap_capture #(
    parameter int NBITS      = 12,
    parameter int NSAMP      = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NBITS*NSAMP-1:0]  dat_i,
    input  logic                    valid_i,
    input  logic                    arm_i,
    input  logic                    force_trig_i,
    input  logic                    thresh_en_i,
    input  logic [NBITS-2:0]        thresh_i,
    input  logic [DEPTH_LOG2-1:0]   pretrig_i,
    output logic                    armed_o,
    output logic                    triggered_o,
    output logic                    done_o,
    output logic [DEPTH_LOG2-1:0]   start_addr_o,
    input  logic                    rd_en_i,
    input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
    output logic [NBITS*NSAMP-1:0]  rd_dat_o,
    output logic                    rd_valid_o
);
    localparam int W     = NBITS * NSAMP;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

    state_t                 state_q;
    logic [W-1:0]           dat_q;
    logic                   vld_q;
    logic                   force_q;
    logic [DEPTH_LOG2-1:0]  wptr_q;
    logic [DEPTH_LOG2-1:0]  cnt_q;
    logic [DEPTH_LOG2-1:0]  pre_q;
    logic [DEPTH_LOG2-1:0]  trig_addr_q;
    logic [DEPTH_LOG2-1:0]  start_q;
    logic [W-1:0]           rd_dat_q;
    logic                   rd_valid_q;
    logic [NSAMP-1:0]       lane_hit;
    logic                   trig_d;
    logic                   we_d;

    logic [W-1:0] mem [DEPTH];

    // One register stage in front of both the RAM write and the trigger compare,
    // so the trigger address is always the address of the offending word.
    always_ff @(posedge clk_i) begin
        dat_q <= dat_i;
        if (rst_i) begin
            vld_q   <= 1'b0;
            force_q <= 1'b0;
        end else begin
            vld_q   <= valid_i;
            force_q <= force_trig_i & valid_i;
        end
    end

    // One extra bit of headroom so -2048 against 2047 compares without overflow.
    logic signed [NBITS:0] thr_pos;
    logic signed [NBITS:0] thr_neg;
    assign thr_pos = {2'b00, thresh_i};
    assign thr_neg = -thr_pos;

    genvar gi;
    generate
        for (gi = 0; gi < NSAMP; gi++) begin : g_lane
            logic signed [NBITS:0] s;
            assign s = {dat_q[NBITS*gi+NBITS-1], dat_q[NBITS*gi +: NBITS]};
            assign lane_hit[gi] = (s > thr_pos) || (s < thr_neg);
        end
    endgenerate

    assign trig_d = vld_q && (force_q || (thresh_en_i && (|lane_hit)));
    assign we_d   = vld_q && !rst_i && (state_q inside {S_FILL, S_WAIT, S_POST});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            trig_addr_q <= '0;
            start_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_i) begin
                        wptr_q  <= '0;
                        cnt_q   <= '0;
                        pre_q   <= pretrig_i;
                        start_q <= '0;
                        state_q <= (pretrig_i == '0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    if (vld_q) begin
                        wptr_q <= wptr_q + DEPTH_LOG2'(1);
                        cnt_q  <= cnt_q + DEPTH_LOG2'(1);
                        if (cnt_q + DEPTH_LOG2'(1) == pre_q)
                            state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (vld_q) begin
                        wptr_q <= wptr_q + DEPTH_LOG2'(1);
                        if (trig_d) begin
                            trig_addr_q <= wptr_q;
                            // Remaining post-trigger words: DEPTH-1-pretrig.
                            cnt_q <= ~pre_q;
                            if (pre_q == '1) begin
                                state_q <= S_DONE;
                                start_q <= wptr_q - pre_q;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (vld_q) begin
                        wptr_q <= wptr_q + DEPTH_LOG2'(1);
                        cnt_q  <= cnt_q - DEPTH_LOG2'(1);
                        if (cnt_q == DEPTH_LOG2'(1)) begin
                            state_q <= S_DONE;
                            start_q <= trig_addr_q - pre_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_d)
            mem[wptr_q] <= dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_dat_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i)
                rd_dat_q <= mem[rd_addr_i];
        end
    end

    assign armed_o      = (state_q == S_FILL) || (state_q == S_WAIT);
    assign triggered_o  = (state_q == S_POST) || (state_q == S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign start_addr_o = start_q;
    assign rd_dat_o     = rd_dat_q;
    assign rd_valid_o   = rd_valid_q;
endmodule

// File: tb/tb_biquad_snap_capture.sv
// Directed bench for biquad_snap_capture at DEPTH=16: capture scenarios with a
// read-data scoreboard filled when reads are issued and drained on rd_valid_o.
module tb_biquad_snap_capture;
    localparam int NB = 12;
    localparam int NS = 8;
    localparam int DL = 4;
    localparam int DP = 16;
    localparam int W  = NB * NS;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [W-1:0]  dat_i = '0;
    logic          valid_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          force_trig_i = 1'b0;
    logic          thresh_en_i = 1'b0;
    logic [NB-2:0] thresh_i = '0;
    logic [DL-1:0] pretrig_i = '0;
    logic          armed_o, triggered_o, done_o, rd_valid_o;
    logic [DL-1:0] start_addr_o;
    logic          rd_en_i = 1'b0;
    logic [DL-1:0] rd_addr_i = '0;
    logic [W-1:0]  rd_dat_o;

    biquad_snap_capture #(.NBITS(NB), .NSAMP(NS), .DEPTH_LOG2(DL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .valid_i(valid_i),
        .arm_i(arm_i), .force_trig_i(force_trig_i), .thresh_en_i(thresh_en_i),
        .thresh_i(thresh_i), .pretrig_i(pretrig_i), .armed_o(armed_o),
        .triggered_o(triggered_o), .done_o(done_o), .start_addr_o(start_addr_o),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_dat_o(rd_dat_o),
        .rd_valid_o(rd_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int base  = 0;
    int ovr [int];
    logic [W-1:0] sb [$];

    function automatic logic [W-1:0] rep(int v);
        logic [W-1:0] w;
        for (int k = 0; k < NS; k++) w[NB*k +: NB] = v[NB-1:0];
        return w;
    endfunction

    // Word n: value base+n in every lane, lane 3 optionally overridden.
    function automatic logic [W-1:0] mkword(int n);
        logic [W-1:0] w;
        int o;
        w = rep(base + n);
        if (ovr.exists(n)) begin
            o = ovr[n];
            w[NB*3 +: NB] = o[NB-1:0];
        end
        return w;
    endfunction

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk_i);
        #1;
        if (rd_valid_o) begin
            if (sb.size() == 0) begin
                check("rd_extra", W'(rd_valid_o), W'(0));
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_dat_o, e);
            end
        end
    endtask

    // Invalid cycles carry hostile data and a force pulse to prove they are gated.
    task automatic send_word(int n, bit frc, bit toggle);
        dat_i = mkword(n);
        valid_i = 1'b1;
        force_trig_i = frc;
        tick();
        if (toggle) begin
            valid_i = 1'b0;
            dat_i = rep(2047);
            force_trig_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        force_trig_i = 1'b0;
    endtask

    task automatic read_range(int start, int count, int firstn);
        for (int i = 0; i < count; i++) begin
            rd_en_i = 1'b1;
            rd_addr_i = DL'((start + i) % DP);
            sb.push_back(mkword(firstn + i));
            tick();
        end
        rd_en_i = 1'b0;
        tick();
        check("sb_empty", W'(sb.size()), W'(0));
    endtask

    task automatic capture(int p, int tw, bit use_force, bit toggle, int extra);
        int last;
        int sa;
        last = tw + DP - 1 - p;
        sa = ((tw - p) % DP + DP) % DP;
        pretrig_i = DL'(p);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("armed_after_arm", W'(armed_o), W'(1));
        check("done_after_arm", W'(done_o), W'(0));
        for (int n = 0; n <= last; n++) begin
            send_word(n, use_force && (n == tw), toggle);
            if (n == tw - 1 || n == tw || n == last - 1) begin
                tick();
                if (n == tw - 1) check($sformatf("pre_trig_w%0d", n), W'(triggered_o), W'(0));
                if (n == tw)     check($sformatf("trig_w%0d", n), W'(triggered_o), W'(1));
                if (n == last - 1 && n >= tw) check($sformatf("not_done_w%0d", n), W'(done_o), W'(0));
            end
        end
        tick();
        check("done", W'(done_o), W'(1));
        check("armed_in_done", W'(armed_o), W'(0));
        check("start_addr", W'(start_addr_o), W'(sa));
        for (int n = last + 1; n <= last + extra; n++) send_word(n, 1'b1, toggle);
        tick();
        check("done_held", W'(done_o), W'(1));
        read_range(sa, DP, tw - p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_armed", W'(armed_o), W'(0));
        check("rst_trig", W'(triggered_o), W'(0));
        check("rst_done", W'(done_o), W'(0));
        check("rst_start", W'(start_addr_o), W'(0));
        check("rst_rdv", W'(rd_valid_o), W'(0));
        check("rst_rdd", rd_dat_o, W'(0));

        // Forced trigger, pretrig 4, trigger on word 10, then the same with valid toggling.
        capture(4, 10, 1'b1, 1'b0, 3);
        capture(4, 10, 1'b1, 1'b1, 3);

        // Threshold 100: exactly +/-100 must not trigger, -101 on word 20 must.
        thresh_en_i = 1'b1;
        thresh_i = 11'd100;
        ovr[12] = 100;
        ovr[15] = -100;
        ovr[20] = -101;
        capture(4, 20, 1'b0, 1'b0, 2);
        ovr.delete();
        thresh_en_i = 1'b0;

        // Pretrig extremes.
        capture(0, 0, 1'b1, 1'b0, 2);
        capture(15, 20, 1'b1, 1'b0, 2);

        // Ignored force in FILL, ignored arm in WAIT, reset mid-POST.
        base = 200;
        pretrig_i = DL'(4);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        for (int n = 0; n <= 14; n++) begin
            if (n == 6) begin
                arm_i = 1'b1;
                pretrig_i = DL'(0);
            end
            send_word(n, (n == 2) || (n == 10), 1'b0);
            arm_i = 1'b0;
        end
        tick();
        check("mid_post_trig", W'(triggered_o), W'(1));
        check("mid_post_done", W'(done_o), W'(0));
        rst_i = 1'b1;
        dat_i = mkword(15);
        valid_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("post_rst_armed", W'(armed_o), W'(0));
        check("post_rst_trig", W'(triggered_o), W'(0));
        check("post_rst_done", W'(done_o), W'(0));
        for (int n = 16; n <= 19; n++) send_word(n, n == 17, 1'b0);
        tick();
        check("idle_armed", W'(armed_o), W'(0));
        check("idle_trig", W'(triggered_o), W'(0));
        read_range(0, 15, 0);
        rd_en_i = 1'b1;
        rd_addr_i = DL'(15);
        sb.push_back(rep(15));
        tick();
        rd_en_i = 1'b0;
        tick();
        check("sb_empty_a15", W'(sb.size()), W'(0));
        base = 300;
        capture(0, 0, 1'b1, 1'b0, 1);

        // Most negative sample against the largest threshold, then a single read.
        base = 0;
        thresh_en_i = 1'b1;
        thresh_i = 11'd2047;
        ovr[3] = -2048;
        capture(0, 3, 1'b0, 1'b0, 2);
        rd_en_i = 1'b1;
        rd_addr_i = DL'(3);
        sb.push_back(mkword(3));
        tick();
        rd_en_i = 1'b0;
        check("rdv_one_cycle", W'(rd_valid_o), W'(1));
        tick();
        check("rdv_drop", W'(rd_valid_o), W'(0));
        check("rd_hold", rd_dat_o, mkword(3));
        check("sb_final", W'(sb.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
